// File: rtl/div_pkg.sv
// Shared definitions for the signed 32-bit restoring divider.
// Holds the FSM state encoding, the default operand width and the step count.
// No ports; imported by div and div_step.
package div_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int STEPS     = 32;
  localparam int CNT_W     = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

endpackage

// File: rtl/div_step.sv
// One unsigned restoring-division step, purely combinational.
// Ports: rem/quo/dvsr in, rem_nxt/quo_nxt out; zero latency, no backpressure.
// Shifts {rem,quo} left by one, trial-subtracts dvsr, keeps the result if non-negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvsr,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // One extra bit keeps the carry out of the shifted remainder; the MSB of
  // the trial difference is then a clean "borrow" (negative) indicator.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_nxt = trial[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div.sv
// Signed multi-cycle divider (MIPS DIV semantics): lo = quotient, hi = remainder.
// Ports: clock, reset (async active-low), A/B operands, div_in start; hi/lo/div_out/div_zero registered.
// Latency 33 edges after start; starts while busy are ignored; B==0 flags and pulses next cycle.
module div
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             div_in,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_out,
  output logic             div_zero
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic [CNT_W-1:0] cnt;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // Magnitudes as unsigned values; the most negative operand maps to 2^(W-1),
  // which is representable unsigned, so no special case is needed.
  assign a_abs = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign b_abs = B[WIDTH-1] ? (~B + 1'b1) : B;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem     (rem),
    .quo     (quo),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      div_out  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      div_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (div_in) begin
            if (B == '0) begin
              div_zero <= 1'b1;
              div_out  <= 1'b1;
            end else begin
              // Remainder starts at zero; the dividend magnitude shifts in
              // through the quotient register one bit per step.
              rem      <= '0;
              quo      <= a_abs;
              dvsr     <= b_abs;
              neg_r    <= A[WIDTH-1];
              neg_q    <= A[WIDTH-1] ^ B[WIDTH-1];
              cnt      <= CNT_LOAD;
              div_zero <= 1'b0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_LAST) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          lo      <= neg_q ? (~quo + 1'b1) : quo;
          hi      <= neg_r ? (~rem + 1'b1) : rem;
          div_out <= 1'b1;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is required to work.
REQ-002 clock  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 A  input  32  signed dividend, sampled only on the start edge.
REQ-005 B  input  32  signed divisor, sampled only on the start edge.
REQ-006 div_in  input  1  start request, sampled on the rising edge of clock.
REQ-007 hi  output  32  signed remainder, registered.
REQ-008 lo  output  32  signed quotient, registered.
REQ-009 div_out  output  1  one-cycle done pulse, registered.
REQ-010 div_zero  output  1  divide-by-zero flag, registered.

Function
REQ-011 States SHALL be IDLE, CALC and FIX, with no other states.
REQ-012 In IDLE, div_in=1 with B!=0 SHALL latch |A| and |B|, the sign of A, and the sign of A xor B; it SHALL load the step counter with 32, clear div_zero and enter CALC.
REQ-013 In IDLE, div_in=1 with B==0 SHALL set div_zero=1 and pulse div_out on the next cycle, leave hi/lo unchanged, and remain in IDLE.
REQ-014 Each CALC edge SHALL perform one unsigned restoring step:
  - shift the {remainder, quotient} pair left by 1;
  - trial-subtract |B| from the remainder;
  - if the result is non-negative, keep it and set the quotient LSB to 1.
REQ-015 The counter SHALL decrement once per CALC edge; after the 32nd step the state SHALL become FIX.
REQ-016 The FIX edge SHALL write the results and set div_out=1 for exactly one cycle, then return to IDLE:
  - lo = quotient, negated if the signs of A and B differ;
  - hi = remainder, negated if A was negative.
REQ-017 Latency SHALL be fixed: div_out is high in the cycle after the 33rd rising edge following the start edge.
REQ-018 Quotient SHALL truncate toward zero, and the remainder SHALL take the sign of the dividend (MIPS DIV semantics).
REQ-019 A=0x80000000 with B=0xFFFFFFFF SHALL produce lo=0x80000000 and hi=0 with no flag.
REQ-020 div_in while in CALC or FIX SHALL be ignored: no restart, no effect on the result.
REQ-021 hi, lo and div_zero SHALL hold their values until the next accepted start or reset.
REQ-022 div_in held high continuously SHALL start a new division on the first IDLE edge after each completion.
REQ-023 The pulse-and-flag behaviour of REQ-013 SHALL also apply when A=0 and B=0.

Reset
REQ-024 reset=0 SHALL asynchronously force:
  - state to IDLE;
  - hi, lo and the internal remainder, quotient and counter registers to 0;
  - div_out and div_zero to 0.
REQ-025 reset asserted mid-operation SHALL abort the division, with no div_out pulse afterwards.
REQ-026 Release of reset SHALL take effect only at a clock edge; the first start accepted SHALL be on a clock edge with reset=1.

Structure
REQ-027 The shared package SHALL hold the state encoding for IDLE, CALC and FIX (2 bits), the WIDTH default and the step count constant 32.
REQ-028 The restoring step SHALL be a combinational sub-module div_step that maps (remainder, quotient, divisor) to (next remainder, next quotient).
REQ-029 Absolute-value and negation logic SHALL stay in div.

Verification
REQ-030 A=100, B=7, start pulse -> after 33 cycles div_out=1 for one cycle, lo=14, hi=2, div_zero=0.
REQ-031 A=-100 (0xFFFFFF9C), B=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
  A=100, B=-7 -> lo=-14, hi=2.
REQ-032 A=5, B=0 -> next cycle div_out=1 and div_zero=1, hi/lo keep their previous values.
  A following 9/3 -> div_zero=0, lo=3, hi=0.
REQ-033 A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
  A=0x80000000, B=1 -> lo=0x80000000, hi=0.
REQ-034 Start 100/7, then div_in=1 with A=1, B=1 at cycle 5 -> only one div_out pulse, result 14/2.
REQ-035 Start 100/7, reset=0 at cycle 10 for 2 cycles -> outputs 0, no div_out, next start of 100/7 completes normally.
